// File: rtl/brnch_pred_bht_btb.sv
// Direct-mapped tagged BHT (saturating counters) + BTB; lookup 0 cycles, update visible next cycle.
// No backpressure: updates during a table clear (busy_o) are dropped. Optional stats: BRNCH_PRED_STATS_EN.
module brnch_pred_bht_btb #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2,
    parameter int TAG_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lkp_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_mispred_i,
    input  logic              flush_i,
    output logic              busy_o
`ifdef BRNCH_PRED_STATS_EN
    ,
    input  logic              stat_clr_i,
    output logic [31:0]       stat_branches_o,
    output logic [31:0]       stat_mispred_o
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_WT = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WN = CTR_WT - CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [ENTRIES-1:0] vld_q;
    logic [TAG_W-1:0]  tag_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q [ENTRIES];
    logic [ADDR_W-1:0] tgt_q [ENTRIES];

    logic [IDX_W-1:0]  lkp_idx, upd_idx;
    logic [TAG_W-1:0]  lkp_tag, upd_tag;
    logic              lkp_hit, upd_hit, upd_acc;
    logic [CTR_W-1:0]  upd_ctr;

    assign lkp_idx = lkp_pc_i[IDX_W+1:2];
    assign lkp_tag = lkp_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup is blanked while the table is being cleared.
    assign lkp_hit       = (state == IDLE) && vld_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign pred_hit_o    = lkp_hit;
    assign pred_taken_o  = lkp_hit && ctr_q[lkp_idx][CTR_W-1];
    assign pred_target_o = lkp_hit ? tgt_q[lkp_idx] : '0;
    assign busy_o        = (state == CLEAR);

    assign upd_hit = vld_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_acc = upd_valid_i && (state == IDLE) && !flush_i;

    always_comb begin
        upd_ctr = ctr_q[upd_idx];
        if (upd_hit) begin
            if (upd_taken_i) begin
                if (ctr_q[upd_idx] != CTR_MAX) upd_ctr = ctr_q[upd_idx] + CTR_W'(1);
            end else begin
                if (ctr_q[upd_idx] != '0) upd_ctr = ctr_q[upd_idx] - CTR_W'(1);
            end
        end else begin
            upd_ctr = upd_taken_i ? CTR_WT : CTR_WN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            vld_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end else if (upd_valid_i) begin
                        vld_q[upd_idx] <= 1'b1;
                        tag_q[upd_idx] <= upd_tag;
                        ctr_q[upd_idx] <= upd_ctr;
                        // A hit keeps its target on not-taken; an allocation always writes it.
                        if (!upd_hit || upd_taken_i) tgt_q[upd_idx] <= upd_target_i;
                    end
                end
                CLEAR: begin
                    vld_q[ptr] <= 1'b0;
                    ctr_q[ptr] <= '0;
                    tgt_q[ptr] <= '0;
                    if (flush_i) begin
                        ptr <= '0;
                    end else if (ptr == IDX_W'(ENTRIES - 1)) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRNCH_PRED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_o <= '0;
            stat_mispred_o  <= '0;
        end else if (stat_clr_i) begin
            stat_branches_o <= '0;
            stat_mispred_o  <= '0;
        end else if (upd_acc) begin
            if (stat_branches_o != 32'hFFFF_FFFF) stat_branches_o <= stat_branches_o + 32'd1;
            if (upd_mispred_i && stat_mispred_o != 32'hFFFF_FFFF)
                stat_mispred_o <= stat_mispred_o + 32'd1;
        end
    end

    logic unused_pc;
    assign unused_pc = ^{lkp_pc_i, upd_pc_i};
`else
    logic unused_pc;
    assign unused_pc = ^{lkp_pc_i, upd_pc_i, upd_mispred_i, upd_acc};
`endif
endmodule

// File: doc/brnch_pred_bht_btb.md
# brnch_pred_bht_btb

Parametrised dynamic branch predictor for the 5-stage MIPS pipeline: a direct-mapped, tagged branch history table of saturating counters plus a branch target buffer. The IF stage gets a taken/not-taken prediction and target for the fetch PC in the same cycle; branches resolved later in the pipeline train the table. This is the successor to the fixed 2-bit single-entry predictor handler. It adds configurable depth, counter width and tag width, a sequenced table flush, and optional statistics counters.

## Interface
- ENTRIES, 16, table depth; power of 2, ≥ 2; IDX_W = log2(ENTRIES)
- ADDR_W, 32, PC/target width
- CTR_W, 2, saturating counter width, ≥ 1
- TAG_W, 8, stored tag width; requires IDX_W+TAG_W+2 ≤ ADDR_W
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- lkp_pc_i  in  ADDR_W  IF-stage fetch PC
- pred_hit_o  out  1  valid entry with matching tag
- pred_taken_o  out  1  predict taken
- pred_target_o  out  ADDR_W  predicted target
- upd_valid_i  in  1  resolved-branch update strobe
- upd_pc_i  in  ADDR_W  PC of the resolved branch
- upd_taken_i  in  1  actual outcome
- upd_target_i  in  ADDR_W  actual target (PC+4+offset<<2)
- upd_mispred_i  in  1  pipeline flagged a misprediction (statistics only)
- flush_i  in  1  start table clear
- busy_o  out  1  clear in progress

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Each entry holds valid, tag, ctr[CTR_W], target[ADDR_W].
- Lookup (combinational on lkp_pc_i): pred_hit_o = valid && tag match. pred_taken_o = hit && ctr[CTR_W-1]. pred_target_o = entry target on hit, else 0.
- Update on upd_valid_i in IDLE:
  - Tag hit: ctr saturating-increments if taken, saturating-decrements if not taken. Saturation is at 2^CTR_W-1 and at 0. Target is overwritten only when taken.
  - Miss: allocate the entry, replacing any existing one. valid=1, tag written. ctr = WT = 2^(CTR_W-1) if taken, WN = WT-1 if not taken. Target = upd_target_i.
- FSM with 2 states:
  - IDLE: flush_i → CLEAR, with clear pointer = 0.
  - CLEAR: each cycle clears valid, ctr and target of entry[ptr] and increments ptr. After ptr = ENTRIES-1 the FSM returns to IDLE. flush_i in CLEAR restarts ptr at 0.
- In CLEAR: busy_o=1, all lookup outputs forced to 0, updates dropped.
- Reset (async, rst_n=0): every entry is invalid with ctr=0 and target=0. FSM is IDLE, ptr=0, busy_o=0, pred_hit_o=0, pred_taken_o=0, pred_target_o=0. Reset asserted mid-CLEAR aborts to IDLE with the table fully cleared.

## Timing
- Lookup latency 0 cycles: combinational from lkp_pc_i and table state.
- Update is written on the clk edge where upd_valid_i=1. It is visible to lookups from the next cycle.
- Lookup and update to the same entry in the same cycle: the lookup returns the pre-update value. There is no bypass.
- flush_i sampled at edge t → busy_o=1 from t through t+ENTRIES-1 inclusive. busy_o=0 and updates accepted again from edge t+ENTRIES.
- Update coincident with the flush_i edge in IDLE: the update is dropped.

## Configuration
- BRNCH_PRED_STATS_EN defined:
  - Adds ports stat_clr_i (in, 1), stat_branches_o (out, 32) and stat_mispred_o (out, 32).
  - stat_branches_o counts accepted updates. stat_mispred_o counts accepted updates with upd_mispred_i=1.
  - Both counters saturate at 32'hFFFFFFFF, reset to 0, and clear synchronously on stat_clr_i. stat_clr_i has priority over a coincident increment.
  - The counters are not affected by flush_i.
- BRNCH_PRED_STATS_EN undefined: no statistics ports or logic. All other behaviour is identical.

## Test plan
- Reset, then lkp_pc_i=32'h40 → pred_hit_o=0, pred_taken_o=0, pred_target_o=0.
- Update pc=32'h40 taken, target=32'h80 (CTR_W=2) → next cycle lookup 32'h40: hit=1, taken=1 (ctr=2'b10), target=32'h80. Then 3 not-taken updates → ctr goes 01, 00, 00 (saturated) and taken=0.
- Alias: update pc=32'h40, then pc=32'h80 (same index, ENTRIES=16, different tag) → lookup 32'h40 hit=0; lookup 32'h80 hit=1.
- Same-cycle lookup and update of 32'h40 from ctr=2'b01 with taken → that cycle taken=0; next cycle taken=1.
- flush_i one cycle with ENTRIES=16 → busy_o high exactly 16 cycles, updates dropped during that window, every lookup hit=0 afterwards. rst_n pulsed low at clear cycle 5 → busy_o=0 immediately.
- With BRNCH_PRED_STATS_EN: 10 updates, 3 with upd_mispred_i=1 → stat_branches_o=10, stat_mispred_o=3. stat_clr_i together with an update → both counters 0.
